// File: rtl/rocket_tlm_master.sv
// ---------------------------------------------------------------------------
// rocket_tlm_master
//
// Rocket-side master for the Gtclk/Invload serial telemetry link. It loads
// the FE board shifter with an active-low Invload pulse. It clocks the word
// out with a slow gated clock and samples the returned data line. It then
// deserialises each word and counts a fixed-length frame.
//
// Ports:
//   clk50       in   single clock domain
//   rst         in   synchronous active-high reset
//   start       in   one-cycle frame request (only honoured in IDLE)
//   abort       in   terminates a frame in progress
//   serial_in   in   asynchronous data from the FE board
//   gtclk       out  registered gated clock toward the FE board
//   invload     out  registered active-low load toward the FE board
//   busy        out  high whenever the sequencer is not idle
//   word_out    out  last received word (MSB received first)
//   word_valid  out  one-cycle strobe qualifying word_out / word_idx
//   word_idx    out  0-based position of word_out inside the frame
//   frame_done  out  one-cycle strobe at normal frame completion
//   frame_sum   out  16-bit running word sum of the frame
//
// Configuration macro: ROCKET_TLM_MASTER_CHKSUM_EN
//   defined   -> frame_sum accumulates the words accepted in the frame
//   undefined -> frame_sum is constant zero and no accumulator exists
// ---------------------------------------------------------------------------
module rocket_tlm_master #(
  parameter int WORD_BITS   = 10,
  parameter int FRAME_WORDS = 52,
  parameter int HALF_CYC    = 8,
  parameter int LOAD_CYC    = 8,
  parameter int GAP_CYC     = 16,
  localparam int IDX_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
  input  logic                 clk50,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 serial_in,
  output logic                 gtclk,
  output logic                 invload,
  output logic                 busy,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_valid,
  output logic [IDX_W-1:0]     word_idx,
  output logic                 frame_done,
  output logic [15:0]          frame_sum
);

  localparam int MAX_CYC = (HALF_CYC > LOAD_CYC) ?
                           ((HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC) :
                           ((LOAD_CYC > GAP_CYC) ? LOAD_CYC : GAP_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int BIT_W   = $clog2(WORD_BITS + 1);

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WORD_BITS - 1);
  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, BIT_LO, BIT_HI, STORE, GAP, DONE
  } state_t;

  state_t               state_q;
  logic                 sync1_q, sync2_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bitCnt_q;
  logic [IDX_W-1:0]     wordCnt_q;
  logic [WORD_BITS-1:0] shift_q;
  logic                 gtclk_q, invload_q;
  logic [WORD_BITS-1:0] wordOut_q;
  logic                 wordValid_q;
  logic [IDX_W-1:0]     wordIdx_q;
  logic                 frameDone_q;
`ifdef ROCKET_TLM_MASTER_CHKSUM_EN
  logic [15:0]          sum_q;
`endif

  // Whole sequencer: synchroniser, phase counters, link pins and the
  // per-word / per-frame result registers. Link pins are set on the edge
  // that enters a state so they are glitch-free and aligned with it.
  // An abort leaves every result register holding its last value.
  always_ff @(posedge clk50) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      bitCnt_q    <= '0;
      wordCnt_q   <= '0;
      shift_q     <= '0;
      gtclk_q     <= 1'b0;
      invload_q   <= 1'b1;
      wordOut_q   <= '0;
      wordValid_q <= 1'b0;
      wordIdx_q   <= '0;
      frameDone_q <= 1'b0;
`ifdef ROCKET_TLM_MASTER_CHKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      sync1_q     <= serial_in;
      sync2_q     <= sync1_q;
      wordValid_q <= 1'b0;
      frameDone_q <= 1'b0;
      cnt_q       <= cnt_q + CNT_W'(1);
      if (abort && state_q != IDLE) begin
        state_q   <= IDLE;
        gtclk_q   <= 1'b0;
        invload_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            // start together with abort is treated as no request
            if (start && !abort) begin
              state_q   <= LOAD;
              cnt_q     <= '0;
              wordCnt_q <= '0;
              invload_q <= 1'b0;
`ifdef ROCKET_TLM_MASTER_CHKSUM_EN
              sum_q     <= '0;
`endif
            end
          end
          LOAD: begin
            if (cnt_q == LOAD_LAST) begin
              state_q   <= BIT_LO;
              cnt_q     <= '0;
              bitCnt_q  <= '0;
              invload_q <= 1'b1;
            end
          end
          BIT_LO: begin
            // sample at the end of the low phase so the slave's output
            // has had HALF_CYC cycles to settle through both synchronisers
            if (cnt_q == HALF_LAST) begin
              shift_q <= {shift_q[WORD_BITS-2:0], sync2_q};
              state_q <= BIT_HI;
              cnt_q   <= '0;
              gtclk_q <= 1'b1;
            end
          end
          BIT_HI: begin
            if (cnt_q == HALF_LAST) begin
              cnt_q    <= '0;
              gtclk_q  <= 1'b0;
              bitCnt_q <= bitCnt_q + BIT_W'(1);
              state_q  <= (bitCnt_q == BIT_LAST) ? STORE : BIT_LO;
            end
          end
          STORE: begin
            wordOut_q   <= shift_q;
            wordIdx_q   <= wordCnt_q;
            wordValid_q <= 1'b1;
`ifdef ROCKET_TLM_MASTER_CHKSUM_EN
            sum_q       <= sum_q + 16'(shift_q);
`endif
            state_q     <= GAP;
            cnt_q       <= '0;
          end
          GAP: begin
            if (cnt_q == GAP_LAST) begin
              cnt_q <= '0;
              if (wordCnt_q == WORD_LAST) begin
                state_q <= DONE;
              end else begin
                wordCnt_q <= wordCnt_q + IDX_W'(1);
                state_q   <= LOAD;
                invload_q <= 1'b0;
              end
            end
          end
          DONE: begin
            frameDone_q <= 1'b1;
            state_q     <= IDLE;
          end
          default: begin
            state_q   <= IDLE;
            gtclk_q   <= 1'b0;
            invload_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign gtclk      = gtclk_q;
  assign invload    = invload_q;
  assign busy       = (state_q != IDLE);
  assign word_out   = wordOut_q;
  assign word_valid = wordValid_q;
  assign word_idx   = wordIdx_q;
  assign frame_done = frameDone_q;
`ifdef ROCKET_TLM_MASTER_CHKSUM_EN
  assign frame_sum  = sum_q;
`else
  assign frame_sum  = '0;
`endif

endmodule
